kaipokrandt_alu_sequencer: RTL and testbench

Control-side initiator for the 16-bit ALU core on the shared system bus. Accepts one ALU instruction at a time over a valid/ready handshake, then drives the register file and ALU load/enable strobes in a fixed bus micro-sequence: operand 1, operand 2 or immediate, execute, write-back. It is the only block that sequences ALU traffic on the bus and guarantees a single bus driver per cycle.

---
 rtl/kaipokrandt_alu_sequencer.sv | 154 +++++++++++++++
 tb/tb_kaipokrandt_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kaipokrandt_alu_sequencer.sv
// Bus micro-sequencer for the 16-bit ALU: LD1, LD2/imm, EXE, WB.
// Optional ALU_SEQ_ILLEGAL_TRAP_EN: drop opcodes 9..15 and raise sticky err.
module kaipokrandt_alu_sequencer #(
    parameter int NREGS  = 4,
    parameter int DATA_W = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [RW-1:0]     instr_rd,
    input  logic [RW-1:0]     instr_rs1,
    input  logic [RW-1:0]     instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [DATA_W-1:0] bus_out,
    output logic [NREGS-1:0]  reg_rd_en,
    output logic [NREGS-1:0]  reg_wr_en,
    output logic              in1_ld,
    output logic              in2_ld,
    output logic              out_ld,
    output logic              alu_out_en,
    output logic [3:0]        alu_op,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SUBI = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;

    typedef enum logic [2:0] {
        IDLE,
        LD1,
        LD2,
        EXE,
        WB
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          op_q;
    logic [RW-1:0]       rd_q;
    logic [RW-1:0]       rs1_q;
    logic [RW-1:0]       rs2_q;
    logic [DATA_W-1:0]   imm_q;
    logic                imm_drive;
    logic                accept;

    assign accept = instr_valid && (state_q == IDLE);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic illegal_in;
    logic err_q;

    assign illegal_in = instr_op > 4'd8;
    assign err        = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept && illegal_in) begin
            err_q <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= instr_op;
                rd_q  <= instr_rd;
                rs1_q <= instr_rs1;
                rs2_q <= instr_rs2;
                imm_q <= instr_imm;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                if (instr_valid && !illegal_in) state_d = LD1;
`else
                if (instr_valid) state_d = LD1;
`endif
            end
            LD1:     state_d = (op_q == OP_NOT) ? EXE : LD2;
            LD2:     state_d = EXE;
            EXE:     state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state and the latched instruction.
    always_comb begin
        instr_ready = 1'b0;
        reg_rd_en   = '0;
        reg_wr_en   = '0;
        in1_ld      = 1'b0;
        in2_ld      = 1'b0;
        out_ld      = 1'b0;
        alu_out_en  = 1'b0;
        done        = 1'b0;
        imm_drive   = 1'b0;
        alu_op      = op_q;
        unique case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                alu_op      = 4'd0;
            end
            LD1: begin
                reg_rd_en[rs1_q] = 1'b1;
                in1_ld           = 1'b1;
            end
            LD2: begin
                in2_ld = 1'b1;
                if (op_q == OP_ADDI || op_q == OP_SUBI) begin
                    imm_drive = 1'b1;
                end else begin
                    reg_rd_en[rs2_q] = 1'b1;
                end
            end
            EXE: begin
                out_ld = 1'b1;
            end
            WB: begin
                alu_out_en      = 1'b1;
                reg_wr_en[rd_q] = 1'b1;
                done            = 1'b1;
            end
            default: begin
                alu_op = 4'd0;
            end
        endcase
    end

    assign bus_out = imm_drive ? imm_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_kaipokrandt_alu_sequencer.sv
// Bench for kaipokrandt_alu_sequencer: register file and ALU model on the bus,
// write-back scoreboard, directed strobe checks.
module tb_kaipokrandt_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_op = '0;
    logic [1:0]  instr_rd = '0;
    logic [1:0]  instr_rs1 = '0;
    logic [1:0]  instr_rs2 = '0;
    logic [15:0] instr_imm = '0;
    wire  [15:0] bus_out;
    logic [3:0]  reg_rd_en;
    logic [3:0]  reg_wr_en;
    logic        in1_ld, in2_ld, out_ld, alu_out_en;
    logic [3:0]  alu_op;
    logic        done, err;

    kaipokrandt_alu_sequencer dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd),
        .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .instr_imm(instr_imm), .bus_out(bus_out),
        .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en),
        .in1_ld(in1_ld), .in2_ld(in2_ld), .out_ld(out_ld),
        .alu_out_en(alu_out_en), .alu_op(alu_op),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment: register file, ALU operand/result registers, bus mux.
    logic [15:0] regs [4];
    logic [15:0] in1_r, in2_r, out_r, bus_v;
    logic        pl_en = 1'b0;
    logic [1:0]  pl_idx = '0;
    logic [15:0] pl_val = '0;

    function automatic logic [15:0] alu_f(input logic [3:0] op,
                                          input logic [15:0] a, b);
        case (op)
            4'd0, 4'd1: return a + b;
            4'd2, 4'd3: return a - b;
            4'd4:       return ~a;
            4'd5:       return a & b;
            4'd6:       return a | b;
            4'd7:       return a ^ b;
            4'd8:       return ~(a ^ b);
            default:    return 16'h0000;
        endcase
    endfunction

    always_comb begin
        bus_v = bus_out;
        if (alu_out_en) bus_v = out_r;
        for (int i = 0; i < 4; i++) begin
            if (reg_rd_en[i]) bus_v = regs[i];
        end
    end

    always @(posedge clk) begin
        if (pl_en) regs[pl_idx] <= pl_val;
        for (int i = 0; i < 4; i++) begin
            if (reg_wr_en[i]) regs[i] <= bus_v;
        end
        if (in1_ld) in1_r <= bus_v;
        if (in2_ld) in2_r <= bus_v;
        if (out_ld) out_r <= alu_f(alu_op, in1_r, in2_r);
    end

    typedef struct {
        logic [1:0]  rd;
        logic [15:0] val;
        int          wb_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic ck(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected write-back.
    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            if (sb.size() == 0) begin
                ck("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                ck("wb_latency", cyc + 1, e.wb_cyc);
                ck("wb_sel", {28'd0, reg_wr_en}, 32'd1 << e.rd);
                @(posedge clk);
                #1;
                ck("wb_value", {16'd0, regs[e.rd]}, {16'd0, e.val});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            ck("bus_excl",
               ($countones(reg_rd_en) + int'(alu_out_en)) <= 1, 1);
        end
    end

    function automatic logic [12:0] vec();
        return {reg_rd_en, reg_wr_en, in1_ld, in2_ld, out_ld,
                alu_out_en, done};
    endfunction

    task automatic sv(input string nm, input logic [12:0] exp);
        ck(nm, {19'd0, vec()}, {19'd0, exp});
    endtask

    task automatic preload(input logic [1:0] idx, input logic [15:0] v);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = v;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Returns at the negedge after the accept edge (first LD1 cycle).
    task automatic issue(input logic [3:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [15:0] imm, input bit push,
                         input logic [15:0] ev, input int lat,
                         input bit hold, output int acc);
        int n;
        instr_valid = 1'b1;
        instr_op = op; instr_rd = rd;
        instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ck("accept_timeout", n < 50, 1);
        acc = cyc + 1;
        if (push) sb.push_back('{rd, ev, acc + lat});
        @(negedge clk);
        if (!hold) instr_valid = 1'b0;
    endtask

    initial begin
        int a0, a1, a2;
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        repeat (2) @(negedge clk);
        ck("rst_ready", instr_ready, 1);
        sv("rst_strobes", 13'd0);
        ck("rst_alu_op", alu_op, 0);
        ck("rst_err", err, 0);
        reset = 1'b0;

        preload(2'd1, 16'h1234);
        preload(2'd2, 16'h0101);
        preload(2'd0, 16'hFFFE);

        // ADD R3 = R1 + R2
        issue(4'd0, 2'd3, 2'd1, 2'd2, 16'h0, 1, 16'h1335, 4, 0, a0);
        sv("add_ld1", {4'b0010, 4'b0000, 5'b10000});
        ck("add_ready_low", instr_ready, 0);
        ck("add_alu_op", alu_op, 0);
        @(negedge clk);
        sv("add_ld2", {4'b0100, 4'b0000, 5'b01000});
        @(negedge clk);
        sv("add_exe", {4'b0000, 4'b0000, 5'b00100});
        @(negedge clk);
        sv("add_wb", {4'b0000, 4'b1000, 5'b00011});
        @(negedge clk);
        ck("add_ready_back", instr_ready, 1);
        sv("add_idle", 13'd0);

        // ADDI R0 = R0 + 5 wraps
        issue(4'd1, 2'd0, 2'd0, 2'd3, 16'h0005, 1, 16'h0003, 4, 0, a0);
        sv("addi_ld1", {4'b0001, 4'b0000, 5'b10000});
        @(negedge clk);
        sv("addi_ld2", {4'b0000, 4'b0000, 5'b01000});
        ck("addi_bus", bus_out, 16'h0005);
        ck("addi_alu_op", alu_op, 1);
        repeat (3) @(negedge clk);

        // NOT R1 = ~R2, no LD2 cycle
        preload(2'd2, 16'h00FF);
        issue(4'd4, 2'd1, 2'd2, 2'd0, 16'h0, 1, 16'hFF00, 3, 0, a0);
        sv("not_ld1", {4'b0100, 4'b0000, 5'b10000});
        @(negedge clk);
        sv("not_exe", {4'b0000, 4'b0000, 5'b00100});
        @(negedge clk);
        sv("not_wb", {4'b0000, 4'b0010, 5'b00011});
        repeat (2) @(negedge clk);

        // Illegal opcode 0xA to R2
        preload(2'd2, 16'h5555);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        issue(4'hA, 2'd2, 2'd1, 2'd3, 16'h0, 0, 16'h0, 0, 0, a0);
        ck("ill_ready", instr_ready, 1);
        sv("ill_strobes", 13'd0);
        ck("ill_err", err, 1);
        repeat (5) @(negedge clk);
        ck("ill_err_held", err, 1);
        ck("ill_r2", regs[2], 16'h5555);
`else
        issue(4'hA, 2'd2, 2'd1, 2'd3, 16'h0, 1, 16'h0000, 4, 0, a0);
        repeat (5) @(negedge clk);
        ck("ill_err", err, 0);
`endif

        // SUB R0 = R3 - R1 aborted by reset in EXE
        issue(4'd2, 2'd0, 2'd3, 2'd1, 16'h0, 0, 16'h0, 0, 0, a0);
        repeat (2) @(negedge clk);
        sv("sub_exe", {4'b0000, 4'b0000, 5'b00100});
        #2 reset = 1'b1;
        #1;
        sv("sub_rst_strobes", 13'd0);
        ck("sub_rst_ready", instr_ready, 1);
        ck("sub_rst_alu_op", alu_op, 0);
        ck("sub_rst_err", err, 0);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        ck("sub_r0_kept", regs[0], 16'h0003);

        // ADD R2 = R3 + R0 after reset
        issue(4'd0, 2'd2, 2'd3, 2'd0, 16'h0, 1, 16'h1338, 4, 0, a0);
        repeat (5) @(negedge clk);

        // Back-to-back AND, OR, XOR with valid held
        issue(4'd5, 2'd0, 2'd3, 2'd1, 16'h0, 1, 16'h1300, 4, 1, a0);
        issue(4'd6, 2'd1, 2'd3, 2'd2, 16'h0, 1, 16'h133D, 4, 1, a1);
        issue(4'd7, 2'd2, 2'd0, 2'd1, 16'h0, 1, 16'h003D, 4, 0, a2);
        ck("b2b_gap1", a1 - a0, 5);
        ck("b2b_gap2", a2 - a1, 5);
        repeat (8) @(negedge clk);

        ck("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
